m_shift_sequencer: RTL and testbench

//   Iterative multi-cycle shift unit for the execute stage. Takes an operand plus the

---
 rtl/m_shift_sequencer.sv | 132 +++++++++++++
 tb/tb_m_shift_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_shift_sequencer.sv
// Iterative multi-cycle shift unit for the execute stage.
// Shifts or rotates an operand by up to 31 positions, moving at most STEP bit positions
// per cycle instead of using a full barrel shifter. One operation is in flight at a time.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   flush      - abort in-flight op and drop any unconsumed result
//   in_valid   - request valid
//   in_ready   - unit is idle and can accept a request
//   in_op      - 0 SHL, 1 SHR, 2 ASR, 3 ROL, 4 ROR, 5-7 reserved (pass-through)
//   in_amount  - shift amount 0..31
//   in_operand - value to shift
//   out_valid  - result valid (registered)
//   out_ready  - consumer accepts the result
//   out_result - shifted value (registered, holds the last value outside DONE)
//   busy       - high in any state other than IDLE
module m_shift_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [4:0]      in_amount,
  input  logic [XLEN-1:0] in_operand,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [4:0] StepAmt = 5'(STEP);
  localparam logic [5:0] XlenAmt = 6'(XLEN);

  localparam logic [2:0] OpShl = 3'd0;
  localparam logic [2:0] OpShr = 3'd1;
  localparam logic [2:0] OpAsr = 3'd2;
  localparam logic [2:0] OpRol = 3'd3;
  localparam logic [2:0] OpRor = 3'd4;

  state_e          state;
  logic [2:0]      op;
  logic [XLEN-1:0] acc;
  logic [4:0]      remain;

  logic [4:0]      step_n;
  logic [5:0]      rot_back;
  logic [XLEN-1:0] acc_next;

  assign in_ready = (state == StIdle);
  assign busy     = (state != StIdle);

  // One step of the shift: move by min(remain, STEP). step_n is never 0 while in SHIFT,
  // so the rotate complement XLEN - step_n stays below XLEN.
  always_comb begin
    step_n   = (remain < StepAmt) ? remain : StepAmt;
    rot_back = XlenAmt - {1'b0, step_n};
    acc_next = acc;
    case (op)
      OpShl:   acc_next = acc << step_n;
      OpShr:   acc_next = acc >> step_n;
      OpAsr:   acc_next = $signed(acc) >>> step_n;
      OpRol:   acc_next = (acc << step_n) | (acc >> rot_back);
      OpRor:   acc_next = (acc >> step_n) | (acc << rot_back);
      default: acc_next = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      op         <= '0;
      acc        <= '0;
      remain     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      // out_result keeps its last value; only the handshake is dropped.
      state     <= StIdle;
      out_valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            op     <= in_op;
            acc    <= in_operand;
            remain <= in_amount;
            if ((in_amount == 5'd0) || (in_op > OpRor)) begin
              state      <= StDone;
              out_valid  <= 1'b1;
              out_result <= in_operand;
            end else begin
              state <= StShift;
            end
          end
        end
        StShift: begin
          acc    <= acc_next;
          remain <= remain - step_n;
          if (remain == step_n) begin
            state      <= StDone;
            out_valid  <= 1'b1;
            out_result <= acc_next;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  a_valid_in_done : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (state == StDone));

  a_result_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> $stable(out_result));

endmodule

// File: tb/tb_m_shift_sequencer.sv
// Self-checking bench for m_shift_sequencer. Four instances with STEP = 4, 1, 2, 8.
// A timeline model (result from a plain shift formula, latency from the ceil rule) is
// compared against every instance on every cycle; directed cases pin literal values.
module tb_m_shift_sequencer;

  localparam int NInst = 4;

  logic        clk = 1'b0;
  logic [3:0]  rst_v;
  logic [3:0]  flush_v;
  logic [3:0]  in_valid_v;
  logic [3:0]  in_ready_v;
  logic [2:0]  op_v      [NInst];
  logic [4:0]  amt_v     [NInst];
  logic [31:0] opnd_v    [NInst];
  logic [3:0]  out_valid_v;
  logic [3:0]  out_ready_v;
  logic [31:0] res_v     [NInst];
  logic [3:0]  busy_v;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  function automatic int unsigned step_of(int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : 8;
  endfunction

  for (genvar gi = 0; gi < NInst; gi++) begin : g_dut
    m_shift_sequencer #(
      .XLEN(32),
      .STEP(step_of(gi))
    ) u_dut (
      .clk       (clk),
      .rst       (rst_v[gi]),
      .flush     (flush_v[gi]),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .in_op     (op_v[gi]),
      .in_amount (amt_v[gi]),
      .in_operand(opnd_v[gi]),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .out_result(res_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation reference: the final value, independent of how it is stepped.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input int amt,
                                            input logic [31:0] x);
    logic [31:0] r;
    case (op)
      3'd0:    r = x << amt;
      3'd1:    r = x >> amt;
      3'd2:    r = $signed(x) >>> amt;
      3'd3:    r = (amt == 0) ? x : ((x << amt) | (x >> (32 - amt)));
      3'd4:    r = (amt == 0) ? x : ((x >> amt) | (x << (32 - amt)));
      default: r = x;
    endcase
    return r;
  endfunction

  // Model: phase 0 idle, 1 working (cnt cycles to go), 2 result presented.
  int          ph   [NInst] = '{default: 0};
  int          cnt  [NInst] = '{default: 0};
  logic [31:0] mres [NInst] = '{default: '0};
  logic [31:0] mout [NInst] = '{default: '0};

  always @(posedge clk) begin
    for (int k = 0; k < NInst; k++) begin
      int lat;
      int amt;
      amt = int'(amt_v[k]);
      if (rst_v[k]) begin
        ph[k]   <= 0;
        mout[k] <= '0;
      end else if (flush_v[k]) begin
        ph[k] <= 0;
      end else begin
        case (ph[k])
          0: if (in_valid_v[k]) begin
            lat = ((amt == 0) || (op_v[k] > 3'd4)) ? 1
                : 1 + (amt + int'(step_of(k)) - 1) / int'(step_of(k));
            mres[k] <= ref_shift(op_v[k], amt, opnd_v[k]);
            if (lat == 1) begin
              ph[k]   <= 2;
              mout[k] <= ref_shift(op_v[k], amt, opnd_v[k]);
            end else begin
              ph[k]  <= 1;
              cnt[k] <= lat - 1;
            end
          end
          1: begin
            cnt[k] <= cnt[k] - 1;
            if (cnt[k] == 1) begin
              ph[k]   <= 2;
              mout[k] <= mres[k];
            end
          end
          default: if (out_ready_v[k]) ph[k] <= 0;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int k = 0; k < NInst; k++) begin
        chk($sformatf("u%0d_in_ready", k), 32'(in_ready_v[k]), 32'(ph[k] == 0));
        chk($sformatf("u%0d_busy", k), 32'(busy_v[k]), 32'(ph[k] != 0));
        chk($sformatf("u%0d_out_valid", k), 32'(out_valid_v[k]), 32'(ph[k] == 2));
        chk($sformatf("u%0d_out_result", k), res_v[k], mout[k]);
      end
    end
  end

  // Directed op on instance 0 (STEP=4): literal result and latency, optional hold.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [4:0] amt,
                        input logic [31:0] x, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    @(negedge clk);
    chk({nm, "_ready_before"}, 32'(in_ready_v[0]), 32'd1);
    in_valid_v[0]  = 1'b1;
    op_v[0]        = op;
    amt_v[0]       = amt;
    opnd_v[0]      = x;
    out_ready_v[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    lat = 1;
    while (!out_valid_v[0] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_result"}, res_v[0], exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, "_hold_valid"}, 32'(out_valid_v[0]), 32'd1);
      chk({nm, "_hold_result"}, res_v[0], exp);
      chk({nm, "_hold_in_ready"}, 32'(in_ready_v[0]), 32'd0);
    end
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    chk({nm, "_valid_after"}, 32'(out_valid_v[0]), 32'd0);
    chk({nm, "_ready_after"}, 32'(in_ready_v[0]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_v       = 4'hF;
    flush_v     = 4'h0;
    in_valid_v  = 4'h0;
    out_ready_v = 4'h0;
    for (int k = 0; k < NInst; k++) begin
      op_v[k]   = '0;
      amt_v[k]  = '0;
      opnd_v[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_v  = 4'h0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("reset_out_result", res_v[0], 32'h0);
    chk("reset_busy", 32'(busy_v[0]), 32'd0);
    chk("reset_in_ready", 32'(in_ready_v[0]), 32'd1);

    run_op("shl31", 3'd0, 5'd31, 32'h0000_0001, 32'h8000_0000, 9, 0);
    run_op("asr4", 3'd2, 5'd4, 32'h8000_00F0, 32'hF800_000F, 2, 0);
    run_op("shr4", 3'd1, 5'd4, 32'h8000_00F0, 32'h0800_000F, 2, 0);
    run_op("ror8", 3'd4, 5'd8, 32'h1234_5678, 32'h7812_3456, 3, 0);
    run_op("rol0", 3'd3, 5'd0, 32'h1234_5678, 32'h1234_5678, 1, 0);
    run_op("rsvd6", 3'd6, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 3);
    run_op("rol1", 3'd3, 5'd1, 32'h8000_0001, 32'h0000_0003, 2, 0);

    // Flush while shifting: SHL by 20 is aborted two cycles in.
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    op_v[0]       = 3'd0;
    amt_v[0]      = 5'd20;
    opnd_v[0]     = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("flush_busy_before", 32'(busy_v[0]), 32'd1);
    flush_v[0] = 1'b1;
    @(posedge clk);
    #1;
    flush_v[0] = 1'b0;
    chk("flush_in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("flush_busy", 32'(busy_v[0]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("flush_no_valid", 32'(out_valid_v[0]), 32'd0);
    end
    run_op("post_flush", 3'd0, 5'd20, 32'h0000_0001, 32'h0010_0000, 6, 0);

    // Reset while a result waits in DONE.
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    op_v[0]       = 3'd4;
    amt_v[0]      = 5'd8;
    opnd_v[0]     = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    n = 0;
    while (!out_valid_v[0] && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_done_valid", 32'(out_valid_v[0]), 32'd1);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    chk("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("rst_out_result", res_v[0], 32'h0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_in_ready", 32'(in_ready_v[0]), 32'd1);

    // Random traffic on every STEP variant, checked by the per-cycle model.
    for (int k = 0; k < NInst; k++) begin
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        in_valid_v[k]  = ($urandom_range(0, 2) != 0);
        op_v[k]        = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
          0:       amt_v[k] = 5'd0;
          1:       amt_v[k] = 5'd31;
          2:       amt_v[k] = 5'(step_of(k) * $urandom_range(1, 3));
          default: amt_v[k] = 5'($urandom_range(0, 31));
        endcase
        opnd_v[k]      = $urandom;
        out_ready_v[k] = ($urandom_range(0, 3) != 0);
        flush_v[k]     = ($urandom_range(0, 39) == 0);
        rst_v[k]       = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b1;
      flush_v[k]     = 1'b0;
      rst_v[k]       = 1'b0;
    end

    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
